// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm controller slice.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int SNOOZE_CNT_W = 3;

  localparam int DEF_RING_TICKS   = 16;
  localparam int DEF_SNOOZE_TICKS = 12;
  localparam int DEF_MAX_SNOOZE   = 3;
  localparam int DEF_TONE_DIV     = 2;

  // Counter width for a count of n states, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_ctrl_btn_edge.sv
// Raw button conditioning: two-flop synchroniser plus a history flop that
// yields a single-cycle pulse on each press, however long it is held.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~hist_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm behaviour stage: ring / snooze / acknowledge FSM with ring timeout,
// sticky missed flag and square-wave buzzer.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_TICKS   = DEF_RING_TICKS,
  parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS,
  parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE,
  parameter int TONE_DIV     = DEF_TONE_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alarm_hit,
  input  logic                    alarm_en,
  input  logic                    ack_btn,
  input  logic                    snooze_btn,
  output logic                    buzzer,
  output logic                    ringing,
  output logic                    snoozing,
  output logic [SNOOZE_CNT_W-1:0] snooze_cnt,
  output logic                    missed
);

  localparam int RW = cnt_w(RING_TICKS);
  localparam int SW = cnt_w(SNOOZE_TICKS);
  localparam int TW = cnt_w(TONE_DIV);

  localparam logic [RW-1:0]           RING_LAST = RW'(RING_TICKS - 1);
  localparam logic [SW-1:0]           SNZ_LAST  = SW'(SNOOZE_TICKS - 1);
  localparam logic [TW-1:0]           TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [SNOOZE_CNT_W-1:0] SNZ_MAX   = SNOOZE_CNT_W'(MAX_SNOOZE);

  logic ack_pulse, snz_pulse;

  btn_edge u_ack (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (ack_btn),
    .pulse_o (ack_pulse)
  );

  btn_edge u_snz (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (snooze_btn),
    .pulse_o (snz_pulse)
  );

  state_t                  state_q, state_d;
  logic [RW-1:0]           ring_tmr_q, ring_tmr_d;
  logic [SW-1:0]           snz_tmr_q, snz_tmr_d;
  logic [TW-1:0]           tone_q, tone_d;
  logic                    buzzer_q, buzzer_d;
  logic [SNOOZE_CNT_W-1:0] snz_cnt_q, snz_cnt_d;
  logic                    missed_q, missed_d;
  logic                    ringing_q, snoozing_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_tmr_q <= '0;
      snz_tmr_q  <= '0;
      tone_q     <= '0;
      buzzer_q   <= 1'b0;
      snz_cnt_q  <= '0;
      missed_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_tmr_q <= ring_tmr_d;
      snz_tmr_q  <= snz_tmr_d;
      tone_q     <= tone_d;
      buzzer_q   <= buzzer_d;
      snz_cnt_q  <= snz_cnt_d;
      missed_q   <= missed_d;
      ringing_q  <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  // buzzer_d defaults low so every non-ringing cycle, including exits, is silent.
  always_comb begin
    state_d    = state_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    tone_d     = tone_q;
    buzzer_d   = 1'b0;
    snz_cnt_d  = snz_cnt_q;
    missed_d   = missed_q;
    unique case (state_q)
      IDLE: begin
        if (alarm_hit && alarm_en) begin
          state_d    = RING;
          ring_tmr_d = '0;
          tone_d     = '0;
          snz_cnt_d  = '0;
          missed_d   = 1'b0;
        end else if (ack_pulse) begin
          missed_d = 1'b0;
        end
      end
      RING: begin
        if (!alarm_en || ack_pulse) begin
          state_d = IDLE;
        end else if (snz_pulse && (snz_cnt_q < SNZ_MAX)) begin
          state_d   = SNOOZE;
          snz_cnt_d = snz_cnt_q + 1'b1;
          snz_tmr_d = '0;
        end else if (ring_tmr_q == RING_LAST) begin
          state_d  = IDLE;
          missed_d = 1'b1;
        end else begin
          ring_tmr_d = ring_tmr_q + 1'b1;
          buzzer_d   = buzzer_q;
          if (tone_q == TONE_LAST) begin
            tone_d   = '0;
            buzzer_d = ~buzzer_q;
          end else begin
            tone_d = tone_q + 1'b1;
          end
        end
      end
      SNOOZE: begin
        if (!alarm_en || ack_pulse) begin
          state_d = IDLE;
        end else if (snz_tmr_q == SNZ_LAST) begin
          state_d    = RING;
          ring_tmr_d = '0;
          tone_d     = '0;
        end else begin
          snz_tmr_d = snz_tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign buzzer     = buzzer_q;
  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snz_cnt_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a behavioural model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_alarm_ctrl;

  localparam int RT = 8;
  localparam int ST = 6;
  localparam int MS = 2;
  localparam int TD = 2;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic       clk = 1'b0;
  logic       reset, alarm_hit, alarm_en, ack_btn, snooze_btn;
  logic       buzzer, ringing, snoozing, missed;
  logic [2:0] snooze_cnt;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .RING_TICKS   (RT),
    .SNOOZE_TICKS (ST),
    .MAX_SNOOZE   (MS),
    .TONE_DIV     (TD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alarm_hit  (alarm_hit),
    .alarm_en   (alarm_en),
    .ack_btn    (ack_btn),
    .snooze_btn (snooze_btn),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  typedef struct {
    int buz;
    int ring;
    int snz;
    int cnt;
    int miss;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode plus elapsed time in the current ring/snooze span.
  int       m_mode, m_rel, m_sel, m_cnt, m_miss;
  bit [2:0] ah, sh;  // [0] = most recent sample of each raw button

  task automatic model_step();
    bit   ackp, snp;
    exp_t e;
    if (reset) begin
      m_mode = M_IDLE; m_rel = 0; m_sel = 0; m_cnt = 0; m_miss = 0;
      ah = '0; sh = '0;
    end else begin
      ackp = ah[1] & ~ah[2];
      snp  = sh[1] & ~sh[2];
      if (m_mode == M_IDLE) begin
        if (alarm_hit && alarm_en) begin
          m_mode = M_RING; m_rel = 0; m_cnt = 0; m_miss = 0;
        end else if (ackp) m_miss = 0;
      end else if (m_mode == M_RING) begin
        if (!alarm_en || ackp) m_mode = M_IDLE;
        else if (snp && m_cnt < MS) begin
          m_mode = M_SNZ; m_cnt++; m_sel = 0;
        end else if (m_rel + 1 >= RT) begin
          m_mode = M_IDLE; m_miss = 1;
        end else m_rel++;
      end else begin
        if (!alarm_en || ackp) m_mode = M_IDLE;
        else if (m_sel + 1 >= ST) begin
          m_mode = M_RING; m_rel = 0;
        end else m_sel++;
      end
      ah = {ah[1:0], ack_btn};
      sh = {sh[1:0], snooze_btn};
    end
    e.ring = (m_mode == M_RING) ? 1 : 0;
    e.snz  = (m_mode == M_SNZ) ? 1 : 0;
    e.buz  = (m_mode == M_RING) ? ((m_rel / TD) % 2) : 0;
    e.cnt  = m_cnt;
    e.miss = m_miss;
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_buzzer",     int'(buzzer),     e.buz);
      chk("sb_ringing",    int'(ringing),    e.ring);
      chk("sb_snoozing",   int'(snoozing),   e.snz);
      chk("sb_snooze_cnt", int'(snooze_cnt), e.cnt);
      chk("sb_missed",     int'(missed),     e.miss);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hit();
    alarm_hit = 1'b1; tick(1); alarm_hit = 1'b0;
  endtask

  task automatic press_ack(input int hold);
    ack_btn = 1'b1; tick(hold); ack_btn = 1'b0;
  endtask

  task automatic press_snz(input int hold);
    snooze_btn = 1'b1; tick(hold); snooze_btn = 1'b0;
  endtask

  task automatic wait_ringing(input bit level, input string name);
    int n = 0;
    while (ringing !== level && n < 40) begin
      tick(1); n++;
    end
    if (ringing !== level) chk(name, int'(ringing), int'(level));
  endtask

  initial begin
    int n;
    reset = 1'b1; alarm_hit = 1'b0; alarm_en = 1'b0; ack_btn = 1'b0; snooze_btn = 1'b0;
    tick(1);
    chk("reset_ringing", int'(ringing), 0);
    chk("reset_missed",  int'(missed), 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Timeout: ring length and missed flag, then ack clears missed
    alarm_en = 1'b1;
    hit();
    n = 0;
    while (ringing === 1'b1 && n < 50) begin
      tick(1); n++;
    end
    chk("timeout_ring_len", n, RT);
    chk("timeout_missed", int'(missed), 1);
    press_ack(1); tick(4);
    chk("ack_clears_missed", int'(missed), 0);

    // Snooze limit
    hit(); tick(2);
    press_snz(1); tick(2);
    chk("snz1_snoozing", int'(snoozing), 1);
    chk("snz1_cnt", int'(snooze_cnt), 1);
    wait_ringing(1'b1, "snz1_rering");
    tick(1);
    press_snz(1); tick(2);
    chk("snz2_cnt", int'(snooze_cnt), 2);
    wait_ringing(1'b1, "snz2_rering");
    tick(1);
    press_snz(1); tick(2);
    chk("snz3_still_ringing", int'(ringing), 1);
    chk("snz3_cnt", int'(snooze_cnt), 2);
    wait_ringing(1'b0, "snz3_timeout");
    chk("snz3_missed", int'(missed), 1);
    press_ack(1); tick(4);

    // Ack wins over a simultaneous snooze press
    hit(); tick(2);
    ack_btn = 1'b1; snooze_btn = 1'b1; tick(1);
    ack_btn = 1'b0; snooze_btn = 1'b0; tick(3);
    chk("prio_ringing", int'(ringing), 0);
    chk("prio_snoozing", int'(snoozing), 0);
    chk("prio_cnt", int'(snooze_cnt), 0);
    chk("prio_missed", int'(missed), 0);

    // Reset mid-RING clears outputs immediately
    hit(); tick(3);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_ringing", int'(ringing), 0);
    chk("rst_mid_buzzer", int'(buzzer), 0);
    chk("rst_mid_snoozing", int'(snoozing), 0);
    chk("rst_mid_cnt", int'(snooze_cnt), 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("rst_mid_missed", int'(missed), 0);

    // Held ack: three-edge latency, then no second ack while still held
    hit(); tick(2);
    ack_btn = 1'b1;
    n = 0;
    while (ringing === 1'b1 && n < 10) begin
      tick(1); n++;
    end
    chk("hold_latency", n, 3);
    tick(2);
    hit(); tick(5);
    chk("hold_no_reack", int'(ringing), 1);
    tick(9);
    ack_btn = 1'b0;
    wait_ringing(1'b0, "hold_timeout");
    press_ack(1); tick(4);

    // Disable / ignore cases
    alarm_en = 1'b0;
    hit(); tick(2);
    chk("dis_hit_ignored", int'(ringing), 0);
    alarm_en = 1'b1;
    hit(); tick(2);
    press_snz(1); tick(2);
    hit();
    chk("snz_hit_ignored", int'(snoozing), 1);
    alarm_en = 1'b0; tick(1);
    chk("snz_dis_snoozing", int'(snoozing), 0);
    chk("snz_dis_ringing", int'(ringing), 0);
    chk("snz_dis_buzzer", int'(buzzer), 0);
    alarm_en = 1'b1;
    tick(2);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      alarm_hit  = ($urandom_range(0, 19) == 0);
      alarm_en   = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 11) == 0) ack_btn = ~ack_btn;
      if ($urandom_range(0, 5) == 0) snooze_btn = ~snooze_btn;
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end else begin
        tick(1);
      end
    end

    alarm_hit = 1'b0; ack_btn = 1'b0; snooze_btn = 1'b0;
    tick(3);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
